// File: rtl/btb_bht_predictor.sv
// btb_bht_predictor: direct-mapped BTB with per-entry saturating counters and branch statistics
module btb_bht_predictor #(
  parameter int ENTRIES  = 64,
  parameter int CTR_BITS = 2,
  parameter int MODE     = 1,
  parameter int STAT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       PC,
  output logic              predict_taken,
  output logic [31:0]       predict_target,
  input  logic              update_valid,
  input  logic              update_stall,
  input  logic [31:0]       update_PC,
  input  logic              real_taken,
  input  logic [31:0]       real_target,
  input  logic              predict_wrong,
  input  logic              clr_tables,
  output logic [STAT_W-1:0] branch_count,
  output logic [STAT_W-1:0] correct,
  output logic [STAT_W-1:0] wrong
);
  localparam int IW = $clog2(ENTRIES);
  localparam int TW = 30 - IW;
  localparam logic [CTR_BITS-1:0] CTR_RST   = CTR_BITS'(2 ** (CTR_BITS - 1) - 1);
  localparam logic [CTR_BITS-1:0] CTR_ALLOC = CTR_BITS'(2 ** (CTR_BITS - 1));
  logic [ENTRIES-1:0]  valid_q;
  logic [TW-1:0]       tag_q    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];
  logic [CTR_BITS-1:0] ctr_q    [ENTRIES];
  logic [STAT_W-1:0]   branch_count_q, correct_q, wrong_q;
  logic [IW-1:0]       idx, u_idx;
  logic [TW-1:0]       tag, u_tag;
  logic                hit, u_hit, upd, wr;
  logic [CTR_BITS-1:0] u_ctr, ctr_d;
  assign idx   = PC[IW+1:2];
  assign tag   = PC[31:IW+2];
  assign u_idx = update_PC[IW+1:2];
  assign u_tag = update_PC[31:IW+2];
  assign hit   = valid_q[idx] && tag_q[idx] == tag;
  assign u_hit = valid_q[u_idx] && tag_q[u_idx] == u_tag;
  assign u_ctr = ctr_q[u_idx];
  assign upd   = update_valid && !update_stall;
  // a not-taken miss leaves the table untouched; a clear discards the update
  assign wr    = upd && !clr_tables && MODE != 0 && (u_hit || real_taken);
  always_comb begin
    ctr_d = !u_hit ? CTR_ALLOC
          : real_taken ? ((&u_ctr) ? u_ctr : u_ctr + 1'b1)
          : ((u_ctr == '0) ? u_ctr : u_ctr - 1'b1);
    predict_taken = MODE == 1 ? hit && ctr_q[idx][CTR_BITS-1]
                  : MODE == 2 ? hit && target_q[idx] < PC
                  : 1'b0;
    predict_target = predict_taken ? target_q[idx] : PC + 32'd4;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q        <= '0;
      branch_count_q <= '0;
      correct_q      <= '0;
      wrong_q        <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_RST;
      end
    end else begin
      if (clr_tables) valid_q <= '0;
      else if (wr) begin
        valid_q[u_idx] <= 1'b1;
        tag_q[u_idx]   <= u_tag;
        ctr_q[u_idx]   <= ctr_d;
        if (real_taken) target_q[u_idx] <= real_target;
      end
      if (upd) begin
        if (!(&branch_count_q)) branch_count_q <= branch_count_q + STAT_W'(1);
        if (predict_wrong && !(&wrong_q)) wrong_q <= wrong_q + STAT_W'(1);
        if (!predict_wrong && !(&correct_q)) correct_q <= correct_q + STAT_W'(1);
      end
    end
  end
  assign branch_count = branch_count_q;
  assign correct      = correct_q;
  assign wrong        = wrong_q;
endmodule
